// File: rtl/wb_pkg.sv
// Shared types and constants for the register writeback block.
// The optional WB_BYPASS_EN macro is consumed by reg_writeback, not by this package.
package wb_pkg;
    localparam int WB_NUM_REGS = 32;
    localparam int WB_ADDR_W   = 5;
    localparam int WB_DATA_W   = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_result_t;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending extension-unit results; storage is registered, head is read directly.
import wb_pkg::*;

module wb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  wb_result_t             wdata_i,
    output wb_result_t             head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

    wb_result_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign full_o    = (count_q == CNT_MAX);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Pointer and occupancy next state; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_push_s && rst_ni) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end
endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: merges ALU and buffered mul/div results, tracks pending destinations.
// Define WB_BYPASS_EN to compile in operand forwarding from ALU, FIFO head and wb output.
import wb_pkg::*;

module reg_writeback #(
    parameter int ADDR_SIZE  = 5,
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [ADDR_SIZE-1:0]          alu_rd,
    input  logic signed [XLEN-1:0]        alu_data,
    input  logic                          ext_valid,
    output logic                          ext_ready,
    input  logic [ADDR_SIZE-1:0]          ext_rd,
    input  logic signed [XLEN-1:0]        ext_data,
    input  logic                          issue_valid,
    input  logic [ADDR_SIZE-1:0]          issue_rd,
    input  logic [ADDR_SIZE-1:0]          rs1_addr,
    input  logic [ADDR_SIZE-1:0]          rs2_addr,
    output logic                          hazard1,
    output logic                          hazard2,
    output logic                          fwd_valid1,
    output logic                          fwd_valid2,
    output logic signed [XLEN-1:0]        fwd_data1,
    output logic signed [XLEN-1:0]        fwd_data2,
    output logic                          wb_write_enable,
    output logic [ADDR_SIZE-1:0]          wb_write_addr,
    output logic signed [XLEN-1:0]        wb_write_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    wb_result_t                push_data_s, head_s;
    logic                      fifo_full_s, fifo_empty_s;
    logic                      alu_take_s, ext_push_s, fifo_pop_s;
    logic                      wb_en_q, wb_en_d;
    logic [ADDR_SIZE-1:0]      wb_addr_q, wb_addr_d;
    logic signed [XLEN-1:0]    wb_data_q, wb_data_d;
    logic [WB_NUM_REGS-1:0]    busy_q, busy_d;

    assign alu_take_s       = alu_valid && (alu_rd != '0);
    assign ext_ready        = !fifo_full_s;
    assign ext_push_s       = ext_valid && ext_ready && (ext_rd != '0);
    assign fifo_pop_s       = !alu_take_s && !fifo_empty_s;
    assign push_data_s.addr = WB_ADDR_W'(ext_rd);
    assign push_data_s.data = WB_DATA_W'(ext_data);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (ext_push_s),
        .pop_i   (fifo_pop_s),
        .wdata_i (push_data_s),
        .head_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count)
    );

    // Output selection (ALU wins over FIFO) and scoreboard update; set beats clear.
    always_comb begin
        wb_en_d   = 1'b0;
        wb_addr_d = '0;
        wb_data_d = '0;
        busy_d    = busy_q;
        if (alu_take_s) begin
            wb_en_d   = 1'b1;
            wb_addr_d = alu_rd;
            wb_data_d = alu_data;
        end else if (!fifo_empty_s) begin
            wb_en_d   = 1'b1;
            wb_addr_d = ADDR_SIZE'(head_s.addr);
            wb_data_d = XLEN'(head_s.data);
        end else begin
            wb_en_d   = 1'b0;
        end
        if (wb_en_q) begin
            busy_d[wb_addr_q] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // Registered writeback port and scoreboard.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wb_write_enable = wb_en_q;
    assign wb_write_addr   = wb_addr_q;
    assign wb_write_data   = wb_data_q;

`ifdef WB_BYPASS_EN
    // Youngest producer first: ALU, then FIFO head, then the result being written.
    function automatic logic [XLEN:0] bypass(input logic [ADDR_SIZE-1:0] rs);
        logic [XLEN:0] r;
        r = '0;
        if (alu_take_s && (alu_rd == rs)) begin
            r = {1'b1, alu_data};
        end else if (!fifo_empty_s && (ADDR_SIZE'(head_s.addr) == rs)) begin
            r = {1'b1, XLEN'(head_s.data)};
        end else if (wb_en_q && (wb_addr_q == rs)) begin
            r = {1'b1, wb_data_q};
        end else begin
            r = '0;
        end
        return r;
    endfunction
`endif

    // Source hazard and forwarding; x0 is never marked busy.
    always_comb begin
        hazard1 = (rs1_addr != '0) && busy_q[rs1_addr];
        hazard2 = (rs2_addr != '0) && busy_q[rs2_addr];
`ifdef WB_BYPASS_EN
        {fwd_valid1, fwd_data1} = bypass(rs1_addr);
        {fwd_valid2, fwd_data2} = bypass(rs2_addr);
        hazard1 = hazard1 && !fwd_valid1;
        hazard2 = hazard2 && !fwd_valid2;
`else
        fwd_valid1 = 1'b0;
        fwd_valid2 = 1'b0;
        fwd_data1  = '0;
        fwd_data2  = '0;
`endif
    end
endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: queue-level reference model, decoupled writeback monitor.
module tb_reg_writeback;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               alu_valid = 1'b0, ext_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]         alu_rd = '0, ext_rd = '0, issue_rd = '0, rs1_addr = '0, rs2_addr = '0;
    logic signed [31:0] alu_data = '0, ext_data = '0;
    logic               ext_ready, hazard1, hazard2, fwd_valid1, fwd_valid2, wb_write_enable;
    logic signed [31:0] fwd_data1, fwd_data2, wb_write_data;
    logic [4:0]         wb_write_addr;
    logic [2:0]         fifo_count;

    always #5 clk = ~clk;

    reg_writeback #(.ADDR_SIZE(5), .XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_rd(ext_rd), .ext_data(ext_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard1(hazard1), .hazard2(hazard2),
        .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
        .fifo_count(fifo_count)
    );

    typedef struct { logic [4:0] a; logic [31:0] d; } res_t;
    res_t       exp_q[$];
    res_t       mfifo[$];
    bit         mbusy[32];
    bit         m_wb_en = 1'b0;
    logic [4:0] m_wb_a = '0;
    logic [31:0] m_wb_d = '0;
    bit         known = 1'b0;
    int         n_cmp = 0, n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected hazard/forward for one source, from the pending-state model.
    function automatic void src_exp(input logic [4:0] s, input bit take, input logic [4:0] ard,
                                    input logic [31:0] ad, output bit hz, output bit fv,
                                    output logic [31:0] fd);
        hz = (s != 5'd0) && mbusy[s];
        fv = 1'b0;
        fd = 32'd0;
`ifdef WB_BYPASS_EN
        if (take && ard == s) begin
            fv = 1'b1; fd = ad;
        end else if (mfifo.size() > 0 && mfifo[0].a == s) begin
            fv = 1'b1; fd = mfifo[0].d;
        end else if (m_wb_en && m_wb_a == s) begin
            fv = 1'b1; fd = m_wb_d;
        end
        if (fv) hz = 1'b0;
`endif
    endfunction

    task automatic step(bit r, bit av, logic [4:0] ard, logic [31:0] ad,
                        bit ev, logic [4:0] erd, logic [31:0] ed,
                        bit iv, logic [4:0] ird, logic [4:0] s1, logic [4:0] s2);
        bit take, rdy, acc, hz, fv, wv;
        logic [31:0] fd;
        res_t w;
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        ext_valid = ev; ext_rd = erd; ext_data = ed;
        issue_valid = iv; issue_rd = ird; rs1_addr = s1; rs2_addr = s2;
        @(negedge clk);
        take = av && (ard != 5'd0);
        rdy  = (mfifo.size() != DEPTH);
        acc  = ev && rdy && (erd != 5'd0);
        if (known) begin
            chk("ext_ready", ext_ready, rdy);
            chk("fifo_count", fifo_count, mfifo.size());
            src_exp(s1, take, ard, ad, hz, fv, fd);
            chk("hazard1", hazard1, hz);
            chk("fwd_valid1", fwd_valid1, fv);
            chk("fwd_data1", $unsigned(fwd_data1), fd);
            src_exp(s2, take, ard, ad, hz, fv, fd);
            chk("hazard2", hazard2, hz);
            chk("fwd_valid2", fwd_valid2, fv);
            chk("fwd_data2", $unsigned(fwd_data2), fd);
        end
        @(posedge clk);
        if (!r) begin
            mfifo.delete();
            mbusy = '{default: 1'b0};
            m_wb_en = 1'b0; m_wb_a = '0; m_wb_d = '0;
            known = 1'b1;
        end else begin
            wv = 1'b0;
            if (take) begin
                w = '{ard, ad}; wv = 1'b1;
            end else if (mfifo.size() > 0) begin
                w = mfifo.pop_front(); wv = 1'b1;
            end
            if (m_wb_en) mbusy[m_wb_a] = 1'b0;
            if (iv && ird != 5'd0) mbusy[ird] = 1'b1;
            if (acc) mfifo.push_back('{erd, ed});
            m_wb_en = wv;
            if (wv) begin
                m_wb_a = w.a; m_wb_d = w.d;
                exp_q.push_back(w);
            end
        end
        #1;
    endtask

    task automatic idle(logic [4:0] s1, logic [4:0] s2);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, s1, s2);
    endtask

    // Monitor: every registered writeback is matched against the expected order.
    initial begin
        res_t w;
        forever begin
            @(negedge clk);
            if (wb_write_enable) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", wb_write_enable, 1'b0);
                end else begin
                    w = exp_q.pop_front();
                    chk("wb_addr", wb_write_addr, w.a);
                    chk("wb_data", $unsigned(wb_write_data), w.d);
                end
            end else begin
                chk("wb_idle_addr", wb_write_addr, 5'd0);
                chk("wb_idle_data", $unsigned(wb_write_data), 32'd0);
            end
        end
    end

    initial begin
        int k;
        bit rdy;
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        // Single ALU write, with busy tracking of x5
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0);
        step(1'b1, 1'b1, 5'd5, 32'h0000_002A, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd0);
        // ALU and ext together: ALU first, ext one cycle later
        step(1'b1, 1'b1, 5'd3, 32'd33, 1'b1, 5'd7, 32'hFFFF_FFF0, 1'b0, 5'd0, 5'd7, 5'd3);
        idle(5'd7, 5'd3);
        idle(5'd7, 5'd0);
        // FIFO fills under continuous ALU traffic, then drains in order
        k = 0;
        for (int c = 0; c < 16; c++) begin
            rdy = (mfifo.size() != DEPTH);
            step(1'b1, c < 6, 5'(1 + c), 32'(1000 + c), k < 5, 5'(10 + k), 32'(100 + k),
                 1'b0, 5'd0, 5'(10 + k), 5'd12);
            if (rdy && k < 5) k++;
        end
        // Issue and writeback of x9 in the same cycle keep it busy
        step(1'b1, 1'b1, 5'd9, 32'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        idle(5'd9, 5'd0);
        // x0 destinations are discarded
        step(1'b1, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd6, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        // Reset with a partially filled FIFO and busy x4
        step(1'b1, 1'b1, 5'd1, 32'd1, 1'b1, 5'd20, 32'd20, 1'b1, 5'd4, 5'd4, 5'd4);
        step(1'b1, 1'b1, 5'd2, 32'd2, 1'b1, 5'd21, 32'd21, 1'b0, 5'd0, 5'd4, 5'd4);
        step(1'b1, 1'b1, 5'd3, 32'd3, 1'b1, 5'd22, 32'd22, 1'b0, 5'd0, 5'd4, 5'd4);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
        step(1'b1, 1'b1, 5'd4, 32'd44, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
        idle(5'd4, 5'd4);
        // Randomized traffic on a narrow register range to provoke matches
        for (int c = 0; c < 400; c++) begin
            step(1'b1, ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int c = 0; c < DEPTH + 4; c++) idle(5'd1, 5'd2);
        chk("pending_writes", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
